// File: rtl/remote_key_ctrl.sv
// Snake-game key controller fed by the NEC IR receiver: resynchronises its pulses, filters direction commands,
// toggles pause on OK and tracks hold/release. Optional macro REMOTE_BOOST_EN enables the HELD state and boost.
module remote_key_ctrl #(
    parameter int         CLK_FREQ       = 50_000_000,
    parameter int         REL_TIMEOUT_MS = 120,
    parameter int         HOLD_REPEATS   = 3,
    parameter logic [7:0] KEY_UP         = 8'h18,
    parameter logic [7:0] KEY_DOWN       = 8'h52,
    parameter logic [7:0] KEY_LEFT       = 8'h08,
    parameter logic [7:0] KEY_RIGHT      = 8'h5A,
    parameter logic [7:0] KEY_OK         = 8'h1C
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       data_en,
    input  logic [7:0] data,
    input  logic       repeat_en,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [1:0] cmd_dir,
    output logic       pause,
    output logic       boost,
    output logic       key_held
);

    localparam int TIMER_MAX = REL_TIMEOUT_MS * (CLK_FREQ / 1000) - 1;
    localparam int TW        = $clog2(TIMER_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        HELD
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [TW-1:0]   timer;
    logic            timer_reload;
    logic            de_s1, de_s2, de_s3;
    logic            rp_s1, rp_s2, rp_s3;
    logic            data_evt;
    logic            rep_evt;
    logic            is_up, is_down, is_left, is_right, is_ok;
    logic            dir_key;
    logic            mapped;
    logic            map_evt;
    logic            expired;
    logic [1:0]      new_dir;
    logic [1:0]      last_dir;
    logic            load;
    logic            xfer;

    // Two flops tame metastability; the third turns any pulse length into a single-cycle event.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            de_s1 <= 1'b0;
            de_s2 <= 1'b0;
            de_s3 <= 1'b0;
            rp_s1 <= 1'b0;
            rp_s2 <= 1'b0;
            rp_s3 <= 1'b0;
        end else begin
            de_s1 <= data_en;
            de_s2 <= de_s1;
            de_s3 <= de_s2;
            rp_s1 <= repeat_en;
            rp_s2 <= rp_s1;
            rp_s3 <= rp_s2;
        end
    end

    assign data_evt = de_s2 & ~de_s3;
    assign rep_evt  = rp_s2 & ~rp_s3;

    assign is_up    = (data == KEY_UP);
    assign is_down  = (data == KEY_DOWN);
    assign is_left  = (data == KEY_LEFT);
    assign is_right = (data == KEY_RIGHT);
    assign is_ok    = (data == KEY_OK);
    assign dir_key  = is_up | is_down | is_left | is_right;
    assign mapped   = dir_key | is_ok;
    assign map_evt  = data_evt & mapped;
    assign expired  = (timer == '0);

    always_comb begin
        new_dir = 2'b00;
        if (is_down)  new_dir = 2'b01;
        if (is_left)  new_dir = 2'b10;
        if (is_right) new_dir = 2'b11;
    end

    // Opposite directions differ only in bit 0, so a reversal is last_dir with bit 0 flipped.
    assign load = data_evt & dir_key & ~pause
                & (new_dir != {last_dir[1], ~last_dir[0]})
                & ~((new_dir == last_dir) & ~cmd_valid);
    assign xfer = cmd_valid & cmd_ready;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            cmd_valid <= 1'b0;
            cmd_dir   <= 2'b11;
            last_dir  <= 2'b11;
            pause     <= 1'b0;
        end else begin
            if (xfer)
                last_dir <= cmd_dir;
            if (load) begin
                cmd_dir   <= new_dir;
                cmd_valid <= 1'b1;
            end else if (xfer) begin
                cmd_valid <= 1'b0;
            end
            if (data_evt && is_ok)
                pause <= ~pause;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n)
            timer <= '0;
        else if (timer_reload)
            timer <= TW'(TIMER_MAX);
        else if (!expired)
            timer <= timer - 1'b1;
    end

`ifdef REMOTE_BOOST_EN
    localparam int CW = $clog2(HOLD_REPEATS + 1);

    logic [CW-1:0] rep_count;
    logic          count_clr;
    logic          count_inc;
    logic          key_is_dir;

    // Remember whether the active key is a direction; only those may be boosted.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            rep_count  <= '0;
            key_is_dir <= 1'b0;
        end else begin
            if (map_evt)
                key_is_dir <= dir_key;
            if (count_clr)
                rep_count <= '0;
            else if (count_inc && rep_count != CW'(HOLD_REPEATS))
                rep_count <= rep_count + 1'b1;
        end
    end
`endif

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // A fresh data event always takes priority over expiry and repeats.
    always_comb begin
        state_next   = state;
        timer_reload = 1'b0;
`ifdef REMOTE_BOOST_EN
        count_clr    = 1'b0;
        count_inc    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (map_evt) begin
                    state_next   = PRESSED;
                    timer_reload = 1'b1;
`ifdef REMOTE_BOOST_EN
                    count_clr    = 1'b1;
`endif
                end
            end
            PRESSED: begin
                if (map_evt) begin
                    timer_reload = 1'b1;
`ifdef REMOTE_BOOST_EN
                    count_clr    = 1'b1;
`endif
                end else if (rep_evt) begin
                    timer_reload = 1'b1;
`ifdef REMOTE_BOOST_EN
                    count_inc    = 1'b1;
                    if (key_is_dir && rep_count == CW'(HOLD_REPEATS - 1))
                        state_next = HELD;
`endif
                end else if (expired) begin
                    state_next = IDLE;
                end
            end
            HELD: begin
                if (map_evt) begin
                    state_next   = PRESSED;
                    timer_reload = 1'b1;
`ifdef REMOTE_BOOST_EN
                    count_clr    = 1'b1;
`endif
                end else if (rep_evt) begin
                    timer_reload = 1'b1;
                end else if (expired) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign key_held = (state != IDLE);
`ifdef REMOTE_BOOST_EN
    assign boost = (state == HELD);
`else
    assign boost = 1'b0;
`endif

endmodule

// File: tb/tb_remote_key_ctrl.sv
// Directed bench for remote_key_ctrl, run with a 10 kHz clock parameter so the 120 ms timeout is 1200 cycles.
module tb_remote_key_ctrl;

    localparam logic [7:0] K_UP    = 8'h18;
    localparam logic [7:0] K_DOWN  = 8'h52;
    localparam logic [7:0] K_LEFT  = 8'h08;
    localparam logic [7:0] K_RIGHT = 8'h5A;
    localparam logic [7:0] K_OK    = 8'h1C;
`ifdef REMOTE_BOOST_EN
    localparam logic BOOST_EXP = 1'b1;
`else
    localparam logic BOOST_EXP = 1'b0;
`endif

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       data_en;
    logic [7:0] data;
    logic       repeat_en;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_dir;
    logic       pause;
    logic       boost;
    logic       key_held;

    int checks = 0;
    int passed = 0;

    remote_key_ctrl #(
        .CLK_FREQ       (10_000),
        .REL_TIMEOUT_MS (120),
        .HOLD_REPEATS   (3)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .data_en   (data_en),
        .data      (data),
        .repeat_en (repeat_en),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .pause     (pause),
        .boost     (boost),
        .key_held  (key_held)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        data_en   = 1'b0;
        repeat_en = 1'b0;
        cmd_ready = 1'b0;
        data      = 8'h00;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
    endtask

    task automatic press(input logic [7:0] code);
        @(negedge sys_clk);
        data    = code;
        data_en = 1'b1;
        repeat (3) @(negedge sys_clk);
        data_en = 1'b0;
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic pulse_repeat();
        @(negedge sys_clk);
        repeat_en = 1'b1;
        @(negedge sys_clk);
        repeat_en = 1'b0;
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic ready_pulse();
        @(negedge sys_clk);
        cmd_ready = 1'b1;
        @(negedge sys_clk);
        cmd_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (cmd_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", cmd_valid); else passed++;
        checks++; if (cmd_dir !== 2'b11) $display("[TB] FAIL reset_dir: got %b expected 11", cmd_dir); else passed++;
        checks++; if (pause !== 1'b0) $display("[TB] FAIL reset_pause: got %b expected 0", pause); else passed++;
        checks++; if (boost !== 1'b0) $display("[TB] FAIL reset_boost: got %b expected 0", boost); else passed++;
        checks++; if (key_held !== 1'b0) $display("[TB] FAIL reset_held: got %b expected 0", key_held); else passed++;
    endtask

    task automatic test_latency();
        do_reset();
        data    = K_UP;
        data_en = 1'b1;
        @(negedge sys_clk);
        checks++; if (cmd_valid !== 1'b0) $display("[TB] FAIL lat_edge1: got %b expected 0", cmd_valid); else passed++;
        @(negedge sys_clk);
        checks++; if (cmd_valid !== 1'b0) $display("[TB] FAIL lat_edge2: got %b expected 0", cmd_valid); else passed++;
        @(negedge sys_clk);
        checks++; if (cmd_valid !== 1'b1) $display("[TB] FAIL lat_edge3: got %b expected 1", cmd_valid); else passed++;
        checks++; if (cmd_dir !== 2'b00) $display("[TB] FAIL lat_dir: got %b expected 00", cmd_dir); else passed++;
        checks++; if (key_held !== 1'b1) $display("[TB] FAIL lat_held: got %b expected 1", key_held); else passed++;
        cmd_ready = 1'b1;
        @(negedge sys_clk);
        cmd_ready = 1'b0;
        checks++; if (cmd_valid !== 1'b0) $display("[TB] FAIL lat_xfer: got %b expected 0", cmd_valid); else passed++;
        repeat (6244) @(negedge sys_clk);
        data_en = 1'b0;
        repeat (10) @(negedge sys_clk);
        checks++; if (cmd_valid !== 1'b0) $display("[TB] FAIL lat_single: got %b expected 0", cmd_valid); else passed++;
    endtask

    task automatic test_filter();
        do_reset();
        press(K_LEFT);
        checks++; if (cmd_valid !== 1'b0) $display("[TB] FAIL filt_reverse: got %b expected 0", cmd_valid); else passed++;
        press(K_RIGHT);
        checks++; if (cmd_valid !== 1'b0) $display("[TB] FAIL filt_same: got %b expected 0", cmd_valid); else passed++;
        press(K_DOWN);
        checks++; if (cmd_valid !== 1'b1) $display("[TB] FAIL filt_down_valid: got %b expected 1", cmd_valid); else passed++;
        checks++; if (cmd_dir !== 2'b01) $display("[TB] FAIL filt_down_dir: got %b expected 01", cmd_dir); else passed++;
    endtask

    task automatic test_overwrite();
        do_reset();
        press(K_UP);
        ready_pulse();
        press(K_LEFT);
        ready_pulse();
        press(K_UP);
        checks++; if (cmd_dir !== 2'b00) $display("[TB] FAIL ovw_first: got %b expected 00", cmd_dir); else passed++;
        press(K_LEFT);
        checks++; if (cmd_valid !== 1'b1) $display("[TB] FAIL ovw_valid: got %b expected 1", cmd_valid); else passed++;
        checks++; if (cmd_dir !== 2'b10) $display("[TB] FAIL ovw_dir: got %b expected 10", cmd_dir); else passed++;
        ready_pulse();
        @(negedge sys_clk);
        checks++; if (cmd_valid !== 1'b0) $display("[TB] FAIL ovw_single_xfer: got %b expected 0", cmd_valid); else passed++;
        press(K_RIGHT);
        checks++; if (cmd_valid !== 1'b0) $display("[TB] FAIL ovw_last_left: got %b expected 0", cmd_valid); else passed++;
        press(K_DOWN);
        checks++; if (cmd_dir !== 2'b01 || cmd_valid !== 1'b1) $display("[TB] FAIL ovw_down: got %b/%b expected 01/1", cmd_dir, cmd_valid); else passed++;
    endtask

    task automatic test_pause();
        do_reset();
        press(K_OK);
        checks++; if (pause !== 1'b1) $display("[TB] FAIL pause_on: got %b expected 1", pause); else passed++;
        press(K_UP);
        checks++; if (cmd_valid !== 1'b0) $display("[TB] FAIL pause_drop: got %b expected 0", cmd_valid); else passed++;
        pulse_repeat();
        pulse_repeat();
        checks++; if (pause !== 1'b1) $display("[TB] FAIL pause_repeat: got %b expected 1", pause); else passed++;
        press(K_OK);
        checks++; if (pause !== 1'b0) $display("[TB] FAIL pause_off: got %b expected 0", pause); else passed++;
        press(K_UP);
        checks++; if (cmd_valid !== 1'b1) $display("[TB] FAIL pause_resume: got %b expected 1", cmd_valid); else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        press(K_UP);
        ready_pulse();
        press(K_LEFT);
        @(negedge sys_clk);
        data    = K_RIGHT;
        data_en = 1'b1;
        @(negedge sys_clk);
        @(negedge sys_clk);
        cmd_ready = 1'b1;
        @(negedge sys_clk);
        cmd_ready = 1'b0;
        data_en   = 1'b0;
        checks++; if (cmd_valid !== 1'b1) $display("[TB] FAIL b2b_valid: got %b expected 1", cmd_valid); else passed++;
        checks++; if (cmd_dir !== 2'b11) $display("[TB] FAIL b2b_dir: got %b expected 11", cmd_dir); else passed++;
        repeat (4) @(negedge sys_clk);
        press(K_DOWN);
        checks++; if (cmd_dir !== 2'b01) $display("[TB] FAIL b2b_down: got %b expected 01", cmd_dir); else passed++;
        press(K_RIGHT);
        checks++; if (cmd_dir !== 2'b01) $display("[TB] FAIL b2b_last_left: got %b expected 01", cmd_dir); else passed++;
    endtask

    task automatic test_boost();
        do_reset();
        press(K_UP);
        repeat (1090) @(negedge sys_clk);
        pulse_repeat();
        checks++; if (key_held !== 1'b1 || boost !== 1'b0) $display("[TB] FAIL boost_rep1: got %b/%b expected 1/0", key_held, boost); else passed++;
        repeat (1094) @(negedge sys_clk);
        pulse_repeat();
        checks++; if (boost !== 1'b0) $display("[TB] FAIL boost_rep2: got %b expected 0", boost); else passed++;
        repeat (1094) @(negedge sys_clk);
        pulse_repeat();
        checks++; if (boost !== BOOST_EXP) $display("[TB] FAIL boost_rep3: got %b expected %b", boost, BOOST_EXP); else passed++;
        checks++; if (key_held !== 1'b1) $display("[TB] FAIL boost_held3: got %b expected 1", key_held); else passed++;
        repeat (1190) @(negedge sys_clk);
        checks++; if (key_held !== 1'b1 || boost !== BOOST_EXP) $display("[TB] FAIL boost_before_timeout: got %b/%b expected 1/%b", key_held, boost, BOOST_EXP); else passed++;
        repeat (15) @(negedge sys_clk);
        checks++; if (key_held !== 1'b0 || boost !== 1'b0) $display("[TB] FAIL boost_released: got %b/%b expected 0/0", key_held, boost); else passed++;
    endtask

    task automatic test_unmapped();
        do_reset();
        press(8'h45);
        checks++; if (cmd_valid !== 1'b0 || cmd_dir !== 2'b11) $display("[TB] FAIL unmap_cmd: got %b/%b expected 0/11", cmd_valid, cmd_dir); else passed++;
        checks++; if (key_held !== 1'b0 || pause !== 1'b0) $display("[TB] FAIL unmap_state: got %b/%b expected 0/0", key_held, pause); else passed++;
        pulse_repeat();
        checks++; if (key_held !== 1'b0 || boost !== 1'b0) $display("[TB] FAIL idle_repeat: got %b/%b expected 0/0", key_held, boost); else passed++;
    endtask

    task automatic test_reset_midframe();
        do_reset();
        press(K_UP);
        press(K_OK);
        checks++; if (cmd_valid !== 1'b1 || pause !== 1'b1) $display("[TB] FAIL mid_setup: got %b/%b expected 1/1", cmd_valid, pause); else passed++;
        @(negedge sys_clk);
        data    = K_DOWN;
        data_en = 1'b1;
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        data_en   = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (6) @(negedge sys_clk);
        checks++; if (cmd_valid !== 1'b0 || cmd_dir !== 2'b11) $display("[TB] FAIL mid_cmd: got %b/%b expected 0/11", cmd_valid, cmd_dir); else passed++;
        checks++; if (pause !== 1'b0 || key_held !== 1'b0 || boost !== 1'b0) $display("[TB] FAIL mid_flags: got %b/%b/%b expected 0/0/0", pause, key_held, boost); else passed++;
    endtask

    initial begin
        sys_rst_n = 1'b0;
        data_en   = 1'b0;
        repeat_en = 1'b0;
        cmd_ready = 1'b0;
        data      = 8'h00;
        test_reset();
        test_latency();
        test_filter();
        test_overwrite();
        test_pause();
        test_back_to_back();
        test_boost();
        test_unmapped();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
